host_ahb_arbiter: RTL and testbench
===================================

Name: host_ahb_arbiter

Overview:
- Sequences the single AHB-Lite master port toward the crypto/SoC bus and shares it between two requesters.
  - Requester 0: host frame write path.
  - Requester 1: status/read-back path.
- Each requester issues one 32-bit single transfer at a time over a req/ack handshake.
- The block arbitrates between the requesters, then drives the AHB address phase and data phase.
- Returns read data and error status to the requester that owns the transfer.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between r0/r1; 1 = fixed priority, r0 always wins.
- HSIZE_VAL, 3'b010, constant HSIZE driven on every transfer (32-bit).

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; asynchronous, active-low; clock clk
- r0_req  input  1  requester 0 transfer request; held with fields stable until r0_ack
- r0_write  input  1  1 = write, 0 = read
- r0_addr  input  32  word-aligned byte address
- r0_wdata  input  32  write data
- r0_ack  output  1  one-cycle completion strobe
- r0_rdata  output  32  read data, valid while r0_ack is high
- r0_err  output  1  AHB ERROR response flag, valid while r0_ack is high
- r1_req, r1_write, r1_addr, r1_wdata, r1_ack, r1_rdata, r1_err  same as r0_*, for requester 1
- m_ahb_htrans  output  2  IDLE (2'b00) or NONSEQ (2'b10) only
- m_ahb_hwrite  output  1  transfer direction
- m_ahb_hsize  output  3  always HSIZE_VAL
- m_ahb_hburst  output  3  always 3'b000 (SINGLE)
- m_ahb_haddr  output  32  transfer address
- m_ahb_hwdata  output  32  write data
- m_ahb_hrdata  input  32  read data
- m_ahb_hready  input  1  bus ready
- m_ahb_hresp  input  1  AHB-Lite response; 1 = ERROR

Behaviour:
- Reset values: htrans=IDLE, hwrite=0, haddr=0, hwdata=0, r*_ack=0, r*_rdata=0, r*_err=0, state=ST_IDLE, last_gnt=1 (so r0 wins first).
- Reset is asynchronous and may occur mid-transfer. The in-flight transfer is dropped, no ack is issued, and the bus returns to IDLE at once.
- State machine (registered state, combinational next-state):
  - ST_IDLE: if r0_req or r1_req, latch gnt, addr, write, wdata into registers, then go to ST_ADDR. Otherwise stay.
  - ST_ADDR: htrans=NONSEQ with the latched haddr/hwrite. If hready=1, go to ST_DATA; else hold all address signals stable.
  - ST_DATA: htrans=IDLE and hwdata=latched wdata (writes only). If hready=1, go to ST_ACK and capture hrdata and hresp into r*_rdata and r*_err of the granted requester.
  - ST_ACK: r<gnt>_ack=1 for exactly one cycle, last_gnt<=gnt, then go to ST_IDLE. Requesters may drop or change req at this edge.
- Arbitration happens only in ST_IDLE:
  - PRIO_MODE=0: if both requesters request, grant the one != last_gnt; a single requester always wins.
  - PRIO_MODE=1: r0 wins whenever r0_req=1.
- Latency from req seen in ST_IDLE to ack, with zero bus wait states: 4 cycles (IDLE, ADDR, DATA, ACK). Each wait state adds 1 cycle.
- Back-to-back transfers: one IDLE cycle between the ack and the next address phase. Sustained throughput with no waits is 1 transfer per 4 cycles.
- A req that drops before its ack is ignored if the block is still in ST_IDLE. Once latched, the transfer completes regardless.
- AHB-Lite ERROR (2-cycle, hresp=1 with hready=0, then hresp=1 with hready=1): the final cycle completes ST_DATA, and err=1 is returned with the ack.
- r*_rdata and r*_err hold their values until the next ack to the same requester.
- Only one transfer is ever outstanding; the address phase never overlaps a data phase.
- Haddr bits [1:0] pass through unchecked. Requesters guarantee word alignment.

Optional Feature:
- Macro: HOST_AHB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts consecutive hready=0 cycles in ST_ADDR or ST_DATA; it clears on hready=1 and on entry to ST_IDLE.
  - When the count reaches 255, go to ST_ACK with err=1 and rdata=32'hDEAD_BEEF, drive htrans=IDLE, and set sticky output arb_timeout (1 bit, cleared only by reset).
- Not defined: no counter, no arb_timeout port, and the block waits on hready indefinitely.

Test Plan:
- Single write, hready tied 1: r0 write to 0x4000_0010 with 0x1234_5678 -> NONSEQ on cycle 2, hwdata 0x1234_5678 on cycle 3, r0_ack on cycle 4, r0_err=0.
- Read with 3 wait states: r1 read from 0x4000_0020, hrdata=0xCAFE_F00D -> haddr held for 3 extra cycles, r1_ack after 7 cycles with r1_rdata=0xCAFE_F00D.
- Contention, PRIO_MODE=0: r0 and r1 both held high for 4 transfers -> grant order r0, r1, r0, r1; exactly one ack per completed transfer.
- Contention, PRIO_MODE=1: r0 and r1 held high -> only r0 acks while r0_req stays 1; r1 is served after r0 drops.
- ERROR response: slave returns 2-cycle hresp=1 on an r0 write -> r0_ack with r0_err=1; the next transfer is unaffected with err=0.
- Reset mid-transfer: reset_n=0 during ST_DATA -> htrans=IDLE immediately, no ack; after release, the first contended grant goes to r0.

Source files
------------

// File: rtl/host_ahb_arbiter.sv
// host_ahb_arbiter: shares one AHB-Lite master port between two single-transfer
// requesters (r0 = host frame write path, r1 = status/read-back path).
// Only one transfer is ever outstanding. The FSM walks IDLE -> ADDR -> DATA -> ACK.
//
// Parameters:
//   PRIO_MODE  0 = round-robin between r0/r1, 1 = fixed priority (r0 wins)
//   HSIZE_VAL  constant HSIZE driven on every transfer
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   rN_req/write/addr/wdata requester N transfer request, held stable until rN_ack
//   rN_ack                  one-cycle completion strobe
//   rN_rdata/rN_err         read data / ERROR flag, held until the next ack to N
//   m_ahb_*                 AHB-Lite master port (SINGLE bursts, IDLE/NONSEQ only)
//   arb_timeout             sticky bus-hang flag (only with HOST_AHB_ARB_TIMEOUT_EN)
//
// Optional build macro: HOST_AHB_ARB_TIMEOUT_EN adds an 8-bit hready watchdog
// that aborts a hung transfer with err=1 and rdata=32'hDEAD_BEEF.
module host_ahb_arbiter #(
    parameter int unsigned PRIO_MODE = 0,
    parameter logic [2:0]  HSIZE_VAL = 3'b010
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        r0_req,
    input  logic        r0_write,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic [31:0] r0_rdata,
    output logic        r0_err,

    input  logic        r1_req,
    input  logic        r1_write,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic [31:0] r1_rdata,
    output logic        r1_err,

    output logic [1:0]  m_ahb_htrans,
    output logic        m_ahb_hwrite,
    output logic [2:0]  m_ahb_hsize,
    output logic [2:0]  m_ahb_hburst,
    output logic [31:0] m_ahb_haddr,
    output logic [31:0] m_ahb_hwdata,
    input  logic [31:0] m_ahb_hrdata,
    input  logic        m_ahb_hready,
    input  logic        m_ahb_hresp
`ifdef HOST_AHB_ARB_TIMEOUT_EN
    ,
    output logic        arb_timeout
`endif
);

    localparam int unsigned DATA_W       = 32;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam bit          RR_MODE       = (PRIO_MODE == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_gnt;
    logic                r_last_gnt;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_htrans;
    logic                r_hwrite;
    logic [DATA_W-1:0]   r_haddr;
    logic [DATA_W-1:0]   r_hwdata;
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_err0;
    logic                r_err1;

    logic                w_req_any;
    logic                w_gnt;
    logic                w_sel_write;
    logic [DATA_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // Arbitration: a lone requester always wins; on contention round-robin
    // favours the requester that was not served last, fixed priority favours r0.
    assign w_req_any   = r0_req | r1_req;
    assign w_gnt       = (RR_MODE && r0_req && r1_req) ? ~r_last_gnt : ~r0_req;
    assign w_sel_write = w_gnt ? r1_write : r0_write;
    assign w_sel_addr  = w_gnt ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_gnt ? r1_wdata : r0_wdata;

`ifdef HOST_AHB_ARB_TIMEOUT_EN
    localparam int unsigned WDOG_W        = 8;
    localparam int unsigned WDOG_LIMIT    = 255;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    logic [WDOG_W-1:0] r_wdog;
    logic              r_arb_timeout;
    logic              w_bus_phase;
    logic              w_wdog_fire;

    assign w_bus_phase = (r_state == ST_ADDR) || (r_state == ST_DATA);
    // Fires on the stall cycle that brings the count to WDOG_LIMIT.
    assign w_wdog_fire = w_bus_phase && !m_ahb_hready
                         && (r_wdog == WDOG_W'(WDOG_LIMIT - 1));

    // Consecutive hready=0 counter; any other cycle (ready, IDLE, ACK) clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog        <= '0;
            r_arb_timeout <= 1'b0;
        end else begin
            if (w_bus_phase && !m_ahb_hready && !w_wdog_fire) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (w_wdog_fire) begin
                r_arb_timeout <= 1'b1;
            end
        end
    end

    assign arb_timeout = r_arb_timeout;
`endif

    // Transfer sequencer with registered bus and requester outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_wdata    <= '0;
            r_htrans   <= HTRANS_IDLE;
            r_hwrite   <= 1'b0;
            r_haddr    <= '0;
            r_hwdata   <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            // Acks are single-cycle pulses.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
`ifdef HOST_AHB_ARB_TIMEOUT_EN
            if (w_wdog_fire) begin
                r_htrans <= HTRANS_IDLE;
                if (r_gnt) begin
                    r_rdata1 <= TIMEOUT_RDATA;
                    r_err1   <= 1'b1;
                    r_ack1   <= 1'b1;
                end else begin
                    r_rdata0 <= TIMEOUT_RDATA;
                    r_err0   <= 1'b1;
                    r_ack0   <= 1'b1;
                end
                r_state <= ST_ACK;
            end else
`endif
            begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_req_any) begin
                            r_gnt    <= w_gnt;
                            r_haddr  <= w_sel_addr;
                            r_hwrite <= w_sel_write;
                            r_wdata  <= w_sel_wdata;
                            r_htrans <= HTRANS_NONSEQ;
                            r_state  <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        // Address signals stay stable until the slave accepts them.
                        if (m_ahb_hready) begin
                            r_htrans <= HTRANS_IDLE;
                            if (r_hwrite) begin
                                r_hwdata <= r_wdata;
                            end
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        // First half of a 2-cycle ERROR has hready=0 and is just a wait.
                        if (m_ahb_hready) begin
                            if (r_gnt) begin
                                r_rdata1 <= m_ahb_hrdata;
                                r_err1   <= m_ahb_hresp;
                                r_ack1   <= 1'b1;
                            end else begin
                                r_rdata0 <= m_ahb_hrdata;
                                r_err0   <= m_ahb_hresp;
                                r_ack0   <= 1'b1;
                            end
                            r_state <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        r_last_gnt <= r_gnt;
                        r_state    <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign r0_ack       = r_ack0;
    assign r0_rdata     = r_rdata0;
    assign r0_err       = r_err0;
    assign r1_ack       = r_ack1;
    assign r1_rdata     = r_rdata1;
    assign r1_err       = r_err1;
    assign m_ahb_htrans = r_htrans;
    assign m_ahb_hwrite = r_hwrite;
    assign m_ahb_hsize  = HSIZE_VAL;
    assign m_ahb_hburst = HBURST_SINGLE;
    assign m_ahb_haddr  = r_haddr;
    assign m_ahb_hwdata = r_hwdata;

endmodule

// File: tb/tb_host_ahb_arbiter.sv
// tb_host_ahb_arbiter: directed bench for host_ahb_arbiter. A round-robin
// instance (dut) and a fixed-priority instance (dut_p1) share the same stimulus.
module tb_host_ahb_arbiter;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [1:0]  NS = 2'b10;
    localparam logic [1:0]  ID = 2'b00;
    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] FF = 32'hFFFF_FFFF;
    localparam logic [31:0] A0 = 32'h4000_0010;
    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] A1 = 32'h4000_0020;
    localparam logic [31:0] R6 = 32'h1111_2222;
    localparam logic [31:0] C1 = 32'hAAAA_0001;
    localparam logic [31:0] C2 = 32'hAAAA_0002;
    localparam logic [31:0] C3 = 32'hAAAA_0003;
    localparam logic [31:0] C4 = 32'hAAAA_0004;
    localparam int unsigned NV = 24;

    typedef struct {
        logic        q0;
        logic        q1;
        logic [31:0] hr;
        logic [1:0]  e_htrans;
        logic        e_hwrite;
        logic [31:0] e_haddr;
        logic [31:0] e_hwdata;
        logic        e_ack0;
        logic        e_ack1;
        logic [31:0] e_rdata0;
        logic [31:0] e_rdata1;
        logic        e_p1ack0;
        logic        e_p1ack1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_req, r0_write, r1_req, r1_write;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [31:0] hrdata;
    logic        hready, hresp;

    logic        r0_ack, r0_err, r1_ack, r1_err, hwrite;
    logic [31:0] r0_rdata, r1_rdata, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;

    logic        p1_r0_ack, p1_r0_err, p1_r1_ack, p1_r1_err, p1_hwrite;
    logic [31:0] p1_r0_rdata, p1_r1_rdata, p1_haddr, p1_hwdata;
    logic [1:0]  p1_htrans;
    logic [2:0]  p1_hsize, p1_hburst;

    int n_vec = 0;
    int n_miss = 0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    host_ahb_arbiter #(.PRIO_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .m_ahb_htrans(htrans), .m_ahb_hwrite(hwrite), .m_ahb_hsize(hsize),
        .m_ahb_hburst(hburst), .m_ahb_haddr(haddr), .m_ahb_hwdata(hwdata),
        .m_ahb_hrdata(hrdata), .m_ahb_hready(hready), .m_ahb_hresp(hresp)
    );

    host_ahb_arbiter #(.PRIO_MODE(1)) dut_p1 (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(p1_r0_ack), .r0_rdata(p1_r0_rdata), .r0_err(p1_r0_err),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(p1_r1_ack), .r1_rdata(p1_r1_rdata), .r1_err(p1_r1_err),
        .m_ahb_htrans(p1_htrans), .m_ahb_hwrite(p1_hwrite), .m_ahb_hsize(p1_hsize),
        .m_ahb_hburst(p1_hburst), .m_ahb_haddr(p1_haddr), .m_ahb_hwdata(p1_hwdata),
        .m_ahb_hrdata(hrdata), .m_ahb_hready(hready), .m_ahb_hresp(hresp)
    );

    function automatic vec_t mkv(input logic q0, input logic q1, input logic [31:0] hr,
                                 input logic [1:0] ht, input logic hw,
                                 input logic [31:0] ha, input logic [31:0] hd,
                                 input logic a0, input logic a1,
                                 input logic [31:0] rd0, input logic [31:0] rd1,
                                 input logic p0, input logic p1);
        vec_t v;
        v.q0 = q0; v.q1 = q1; v.hr = hr;
        v.e_htrans = ht; v.e_hwrite = hw; v.e_haddr = ha; v.e_hwdata = hd;
        v.e_ack0 = a0; v.e_ack1 = a1; v.e_rdata0 = rd0; v.e_rdata1 = rd1;
        v.e_p1ack0 = p0; v.e_p1ack1 = p1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Per-cycle vectors: inputs, then outputs expected after the next clock edge.
        //             q0 q1 hr  htrans hw haddr hwdata ack0 ack1 rdata0 rdata1 p1a0 p1a1
        tbl[0]  = mkv(H, L, FF, NS, H, A0, Z,  L, L, Z,  Z,  L, L);  // r0 write: address phase
        tbl[1]  = mkv(H, L, FF, ID, H, A0, D0, L, L, Z,  Z,  L, L);  // data phase
        tbl[2]  = mkv(H, L, Z,  ID, H, A0, D0, H, L, Z,  Z,  H, L);  // ack on cycle 4
        tbl[3]  = mkv(L, L, FF, ID, H, A0, D0, L, L, Z,  Z,  L, L);
        tbl[4]  = mkv(L, H, FF, NS, L, A1, D0, L, L, Z,  Z,  L, L);  // r1 read
        tbl[5]  = mkv(L, H, FF, ID, L, A1, D0, L, L, Z,  Z,  L, L);
        tbl[6]  = mkv(L, H, R6, ID, L, A1, D0, L, H, Z,  R6, L, H);
        tbl[7]  = mkv(L, L, FF, ID, L, A1, D0, L, L, Z,  R6, L, L);
        tbl[8]  = mkv(H, H, FF, NS, H, A0, D0, L, L, Z,  R6, L, L);  // contention
        tbl[9]  = mkv(H, H, FF, ID, H, A0, D0, L, L, Z,  R6, L, L);
        tbl[10] = mkv(H, H, C1, ID, H, A0, D0, H, L, C1, R6, H, L);
        tbl[11] = mkv(H, H, FF, ID, H, A0, D0, L, L, C1, R6, L, L);
        tbl[12] = mkv(H, H, FF, NS, L, A1, D0, L, L, C1, R6, L, L);
        tbl[13] = mkv(H, H, FF, ID, L, A1, D0, L, L, C1, R6, L, L);
        tbl[14] = mkv(H, H, C2, ID, L, A1, D0, L, H, C1, C2, H, L);
        tbl[15] = mkv(H, H, FF, ID, L, A1, D0, L, L, C1, C2, L, L);
        tbl[16] = mkv(H, H, FF, NS, H, A0, D0, L, L, C1, C2, L, L);
        tbl[17] = mkv(H, H, FF, ID, H, A0, D0, L, L, C1, C2, L, L);
        tbl[18] = mkv(H, H, C3, ID, H, A0, D0, H, L, C3, C2, H, L);
        tbl[19] = mkv(H, H, FF, ID, H, A0, D0, L, L, C3, C2, L, L);
        tbl[20] = mkv(L, H, FF, NS, L, A1, D0, L, L, C3, C2, L, L);  // r0 drops: p1 serves r1
        tbl[21] = mkv(L, H, FF, ID, L, A1, D0, L, L, C3, C2, L, L);
        tbl[22] = mkv(L, H, C4, ID, L, A1, D0, L, H, C3, C4, L, H);
        tbl[23] = mkv(L, L, FF, ID, L, A1, D0, L, L, C3, C4, L, L);

        reset_n = 1'b0;
        r0_req = 1'b0; r0_write = 1'b0; r0_addr = Z; r0_wdata = Z;
        r1_req = 1'b0; r1_write = 1'b0; r1_addr = Z; r1_wdata = Z;
        hrdata = Z; hready = 1'b1; hresp = 1'b0;
        step();
        step();

        // Reset values on both instances.
        chk("rst htrans", 32'(htrans), 32'(ID));
        chk("rst hwrite", 32'(hwrite), 32'(L));
        chk("rst haddr", haddr, Z);
        chk("rst hwdata", hwdata, Z);
        chk("rst acks", 32'({r0_ack, r1_ack}), 32'd0);
        chk("rst errs", 32'({r0_err, r1_err}), 32'd0);
        chk("rst rdata0", r0_rdata, Z);
        chk("rst rdata1", r1_rdata, Z);
        chk("hsize", 32'(hsize), 32'd2);
        chk("hburst", 32'(hburst), 32'd0);
        chk("p1 rst bus", 32'({p1_htrans, p1_hwrite}), 32'd0);
        chk("p1 rst haddr", p1_haddr, Z);
        chk("p1 rst hwdata", p1_hwdata, Z);
        chk("p1 rst resp", 32'({p1_r0_ack, p1_r1_ack, p1_r0_err, p1_r1_err}), 32'd0);
        chk("p1 rst rdata", p1_r0_rdata | p1_r1_rdata, Z);
        chk("p1 hsize/hburst", 32'({p1_hsize, p1_hburst}), 32'({3'b010, 3'b000}));
        reset_n = 1'b1;

        r0_write = 1'b1; r0_addr = A0; r0_wdata = D0;
        r1_write = 1'b0; r1_addr = A1; r1_wdata = Z;
        for (int i = 0; i < int'(NV); i++) begin
            r0_req = tbl[i].q0;
            r1_req = tbl[i].q1;
            hrdata = tbl[i].hr;
            step();
            chk($sformatf("v%0d htrans", i), 32'(htrans), 32'(tbl[i].e_htrans));
            chk($sformatf("v%0d hwrite", i), 32'(hwrite), 32'(tbl[i].e_hwrite));
            chk($sformatf("v%0d haddr", i), haddr, tbl[i].e_haddr);
            chk($sformatf("v%0d hwdata", i), hwdata, tbl[i].e_hwdata);
            chk($sformatf("v%0d r0_ack", i), 32'(r0_ack), 32'(tbl[i].e_ack0));
            chk($sformatf("v%0d r1_ack", i), 32'(r1_ack), 32'(tbl[i].e_ack1));
            chk($sformatf("v%0d r0_rdata", i), r0_rdata, tbl[i].e_rdata0);
            chk($sformatf("v%0d r1_rdata", i), r1_rdata, tbl[i].e_rdata1);
            chk($sformatf("v%0d errs", i), 32'({r0_err, r1_err}), 32'd0);
            chk($sformatf("v%0d p1 r0_ack", i), 32'(p1_r0_ack), 32'(tbl[i].e_p1ack0));
            chk($sformatf("v%0d p1 r1_ack", i), 32'(p1_r1_ack), 32'(tbl[i].e_p1ack1));
        end

        // r1 read with 3 address-phase wait states: ack lands on cycle 7.
        begin
            logic hr_pat [6] = '{H, L, L, L, H, H};
            logic [1:0] ht_exp [6] = '{NS, NS, NS, NS, ID, ID};
            r0_req = 1'b0; r1_req = 1'b1; r1_addr = A1; r1_write = 1'b0;
            for (int c = 0; c < 6; c++) begin
                hready = hr_pat[c];
                hrdata = (c == 5) ? 32'hCAFE_F00D : FF;
                step();
                chk($sformatf("ws c%0d htrans", c), 32'(htrans), 32'(ht_exp[c]));
                chk($sformatf("ws c%0d haddr", c), haddr, A1);
                chk($sformatf("ws c%0d r1_ack", c), 32'(r1_ack), (c == 5) ? 32'd1 : 32'd0);
            end
            chk("ws r1_rdata", r1_rdata, 32'hCAFE_F00D);
            chk("ws p1 r1_ack", 32'(p1_r1_ack), 32'd1);
            r1_req = 1'b0; hready = 1'b1; hrdata = FF;
            step();
            chk("ws ack drop", 32'(r1_ack), 32'd0);
            chk("ws rdata hold", r1_rdata, 32'hCAFE_F00D);
        end

        // Two-cycle ERROR on an r0 write, then a clean r0 read.
        r0_req = 1'b1; r0_write = 1'b1; r0_addr = 32'h4000_0100; r0_wdata = 32'h0BAD_F00D;
        step();
        chk("err addr htrans", 32'(htrans), 32'(NS));
        chk("err haddr", haddr, 32'h4000_0100);
        step();
        chk("err hwdata", hwdata, 32'h0BAD_F00D);
        hready = 1'b0; hresp = 1'b1;
        step();
        chk("err wait ack", 32'(r0_ack), 32'd0);
        chk("err wait htrans", 32'(htrans), 32'(ID));
        hready = 1'b1;
        step();
        chk("err r0_ack", 32'(r0_ack), 32'd1);
        chk("err r0_err", 32'(r0_err), 32'd1);
        r0_req = 1'b0; hresp = 1'b0;
        step();
        chk("err hold", 32'({r0_ack, r0_err}), 32'b01);
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 32'h4000_0104;
        step();
        chk("post-err hwrite", 32'(hwrite), 32'd0);
        step();
        hrdata = 32'h600D_0001;
        step();
        chk("post-err ack", 32'({r0_ack, r0_err}), 32'b10);
        chk("post-err rdata", r0_rdata, 32'h600D_0001);
        chk("post-err r1 kept", r1_rdata, 32'hCAFE_F00D);
        r0_req = 1'b0; hrdata = FF;
        step();

        // Reset during the data phase of an r0 write.
        r0_req = 1'b1; r0_write = 1'b1; r0_addr = 32'h4000_0200; r0_wdata = 32'h7777_8888;
        step();
        step();
        chk("rmid hwdata", hwdata, 32'h7777_8888);
        #2 reset_n = 1'b0;
        #1;
        chk("rmid htrans", 32'(htrans), 32'(ID));
        chk("rmid haddr", haddr, Z);
        chk("rmid hwdata clr", hwdata, Z);
        chk("rmid r1_rdata clr", r1_rdata, Z);
        step();
        step();
        chk("rmid no ack", 32'({r0_ack, r1_ack, p1_r0_ack, p1_r1_ack}), 32'd0);
        #2 reset_n = 1'b1;
        // Round-robin state would favour r1 here if reset did not restore it.
        r1_req = 1'b1; r1_addr = A1; r1_write = 1'b0;
        step();
        chk("rmid first gnt haddr", haddr, 32'h4000_0200);
        chk("rmid first gnt hwrite", 32'(hwrite), 32'd1);
        step();
        step();
        chk("rmid r0_ack", 32'({r0_ack, r1_ack}), 32'b10);
        chk("rmid p1 r0_ack", 32'(p1_r0_ack), 32'd1);
        r0_req = 1'b0; r1_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
